sw: RTL and testbench

SW -- requirements
Module: sw

---
 rtl/sw.sv | 189 ++++++++++++++++++
 tb/tb_sw.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/sw.sv
// sw: 4x4 wormhole crossbar with a flit FIFO on every input and a
// round-robin arbiter plus registered flit output on every output.
module sw #(
    parameter int PKTW       = 9,
    parameter int FIFO_DEPTH = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [PKTW:0] i0,
    input  logic [PKTW:0] i1,
    input  logic [PKTW:0] i2,
    input  logic [PKTW:0] i3,
    output logic [PKTW:0] o0,
    output logic [PKTW:0] o1,
    output logic [PKTW:0] o2,
    output logic [PKTW:0] o3
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [1:0] T_IDLE = 2'b00;
    localparam logic [1:0] T_HEAD = 2'b10;
    localparam logic [1:0] T_TAIL = 2'b11;
    localparam logic [AW:0] FULL = (AW + 1)'(FIFO_DEPTH);

    logic [PKTW:0] din  [4];
    logic [PKTW:0] dout [4];
    logic [PKTW:0] front[4];
    logic [PKTW:0] mem  [4][FIFO_DEPTH];
    logic [AW-1:0] rd_ptr[4];
    logic [AW-1:0] wr_ptr[4];
    logic [AW:0]   cnt   [4];
    logic [3:0]    empty;
    logic [3:0]    open;
    logic [3:0]    push;
    logic [3:0]    pop;
    logic [3:0]    busy;
    logic [3:0]    req   [4];

    logic [3:0]    locked;
    logic [1:0]    src   [4];
    logic [1:0]    prio  [4];
    logic [3:0]    fwd;
    logic [3:0]    rel;
    logic [3:0]    grant_v;
    logic [1:0]    grant_s[4];

    assign din[0] = i0;
    assign din[1] = i1;
    assign din[2] = i2;
    assign din[3] = i3;
    assign o0 = dout[0];
    assign o1 = dout[1];
    assign o2 = dout[2];
    assign o3 = dout[3];

    // FIFO status and head-of-queue flit per input
    always_comb begin
        for (int p = 0; p < 4; p++) begin
            empty[p] = (cnt[p] == '0);
            front[p] = mem[p][rd_ptr[p]];
        end
    end

    // Accept heads always, bodies/tails only inside an open packet, never when full
    always_comb begin
        push = '0;
        for (int p = 0; p < 4; p++) begin
            if (din[p][PKTW-:2] == T_HEAD)
                push[p] = 1'b1;
            else if (din[p][PKTW-:2] != T_IDLE && open[p])
                push[p] = 1'b1;
            if (cnt[p] == FULL)
                push[p] = 1'b0;
        end
    end

    // Locked outputs pull one flit per cycle; a forwarded tail releases the lock
    always_comb begin
        pop = '0;
        fwd = '0;
        rel = '0;
        for (int o = 0; o < 4; o++) begin
            if (locked[o] && !empty[src[o]]) begin
                fwd[o] = 1'b1;
                pop[src[o]] = 1'b1;
                if (front[src[o]][PKTW-:2] == T_TAIL)
                    rel[o] = 1'b1;
            end
        end
    end

    // An input stays busy while an output holds it, except on its release cycle
    always_comb begin
        busy = '0;
        for (int o = 0; o < 4; o++) begin
            if (locked[o] && !rel[o])
                busy[src[o]] = 1'b1;
        end
    end

    // Request matrix: free input whose queued head flit targets output o
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            for (int o = 0; o < 4; o++) begin
                req[i][o] = !empty[i] && !busy[i]
                    && (front[i][PKTW-:2] == T_HEAD)
                    && (front[i][1:0] == 2'(o));
            end
        end
    end

    // Round-robin search; a releasing output re-arbitrates in the same
    // cycle from the updated pointer so packets can run back-to-back
    always_comb begin
        logic [1:0] start;
        logic [1:0] idx;
        start   = '0;
        idx     = '0;
        grant_v = '0;
        for (int o = 0; o < 4; o++) begin
            grant_s[o] = '0;
            start = rel[o] ? src[o] + 2'd1 : prio[o];
            if (!locked[o] || rel[o]) begin
                for (int k = 0; k < 4; k++) begin
                    idx = start + 2'(k);
                    if (!grant_v[o] && req[idx][o]) begin
                        grant_v[o] = 1'b1;
                        grant_s[o] = idx;
                    end
                end
            end
        end
    end

    // FIFO pointers, occupancy and per-input packet-open tracking
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            open <= '0;
            for (int p = 0; p < 4; p++) begin
                rd_ptr[p] <= '0;
                wr_ptr[p] <= '0;
                cnt[p]    <= '0;
            end
        end else begin
            for (int p = 0; p < 4; p++) begin
                if (push[p])
                    wr_ptr[p] <= wr_ptr[p] + AW'(1);
                if (pop[p])
                    rd_ptr[p] <= rd_ptr[p] + AW'(1);
                cnt[p] <= cnt[p] + (AW + 1)'(push[p]) - (AW + 1)'(pop[p]);
                if (din[p][PKTW-:2] == T_HEAD)
                    open[p] <= 1'b1;
                else if (din[p][PKTW-:2] == T_TAIL)
                    open[p] <= 1'b0;
            end
        end
    end

    // FIFO storage; contents are don't-care while the pointers say empty
    always_ff @(posedge clk) begin
        for (int p = 0; p < 4; p++) begin
            if (push[p])
                mem[p][wr_ptr[p]] <= din[p];
        end
    end

    // Output locks, priority pointers and registered output flits
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            locked <= '0;
            for (int o = 0; o < 4; o++) begin
                src[o]  <= '0;
                prio[o] <= '0;
                dout[o] <= '0;
            end
        end else begin
            for (int o = 0; o < 4; o++) begin
                if (grant_v[o]) begin
                    locked[o] <= 1'b1;
                    src[o]    <= grant_s[o];
                end else if (rel[o]) begin
                    locked[o] <= 1'b0;
                end
                if (rel[o])
                    prio[o] <= src[o] + 2'd1;
                dout[o] <= fwd[o] ? front[src[o]] : '0;
            end
        end
    end
endmodule

// File: tb/tb_sw.sv
// tb_sw: directed-vector bench for the sw crossbar; each vector row
// is driven at a falling edge and outputs are checked before driving.
module tb_sw;
    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] i0, i1, i2, i3;
    logic [9:0] o0, o1, o2, o3;
    logic [9:0] obs[4];

    logic [9:0] vin [4][40];
    logic [9:0] vexp[4][40];
    logic       vrst[40];

    int ncmp = 0;
    int nerr = 0;

    sw #(.PKTW(9), .FIFO_DEPTH(16)) dut (
        .clk(clk), .rst(rst),
        .i0(i0), .i1(i1), .i2(i2), .i3(i3),
        .o0(o0), .o1(o1), .o2(o2), .o3(o3)
    );

    assign obs[0] = o0;
    assign obs[1] = o1;
    assign obs[2] = o2;
    assign obs[3] = o3;

    always #5 clk = ~clk;

    task automatic check(input string tag, input int c, input int p,
                         input logic [9:0] got, input logic [9:0] exp);
        ncmp++;
        assert (got === exp) else begin
            nerr++;
            $error("FAIL %s cyc %0d o%0d: got %h expected %h",
                   tag, c, p, got, exp);
        end
    endtask

    task automatic clear_vec();
        for (int c = 0; c < 40; c++) begin
            vrst[c] = 1'b0;
            for (int p = 0; p < 4; p++) begin
                vin[p][c]  = '0;
                vexp[p][c] = '0;
            end
        end
    endtask

    // Row c: check outputs against vexp[*][c], then drive vin[*][c]/vrst[c]
    task automatic run(input string tag, input int len);
        for (int c = 0; c < len; c++) begin
            @(negedge clk);
            for (int p = 0; p < 4; p++)
                check(tag, c, p, obs[p], vexp[p][c]);
            i0  = vin[0][c];
            i1  = vin[1][c];
            i2  = vin[2][c];
            i3  = vin[3][c];
            rst = vrst[c];
            if (vrst[c]) begin
                #1;
                for (int p = 0; p < 4; p++)
                    check({tag, "_rst"}, c, p, obs[p], 10'h000);
            end
        end
        clear_vec();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        i0 = '0; i1 = '0; i2 = '0; i3 = '0;
        clear_vec();
        repeat (2) @(negedge clk);
        for (int p = 0; p < 4; p++)
            check("reset", 0, p, obs[p], 10'h000);
        rst = 1'b0;

        // single packet i0 -> o0, with stray body/tail on i1 to be dropped
        vin[0][0] = 10'h200; vin[0][1] = 10'h100;
        vin[0][2] = 10'h101; vin[0][3] = 10'h302;
        vin[1][0] = 10'h1AB; vin[1][1] = 10'h3AB;
        vexp[0][3] = 10'h200; vexp[0][4] = 10'h100;
        vexp[0][5] = 10'h101; vexp[0][6] = 10'h302;
        run("t1_o0", 10);

        // single packet i0 -> o1
        vin[0][0] = 10'h291; vin[0][1] = 10'h190;
        vin[0][2] = 10'h191; vin[0][3] = 10'h392;
        vexp[1][3] = 10'h291; vexp[1][4] = 10'h190;
        vexp[1][5] = 10'h191; vexp[1][6] = 10'h392;
        run("t2_o1", 10);

        // each input in turn, 2-flit packets to outputs 3,2,1,0
        vin[0][0] = 10'h203; vin[0][1] = 10'h30F;
        vin[1][2] = 10'h212; vin[1][3] = 10'h31F;
        vin[2][4] = 10'h221; vin[2][5] = 10'h32F;
        vin[3][6] = 10'h230; vin[3][7] = 10'h33F;
        vexp[3][3] = 10'h203; vexp[3][4]  = 10'h30F;
        vexp[2][5] = 10'h212; vexp[2][6]  = 10'h31F;
        vexp[1][7] = 10'h221; vexp[1][8]  = 10'h32F;
        vexp[0][9] = 10'h230; vexp[0][10] = 10'h33F;
        run("t3_each", 13);

        // all inputs, 4-flit packets to o1 at once: served i0,i1,i2,i3
        do_reset();
        for (int p = 0; p < 4; p++) begin
            vin[p][0] = {2'b10, 4'(p), 4'h1};
            vin[p][1] = {2'b01, 4'(p), 4'h0};
            vin[p][2] = {2'b01, 4'(p), 4'h1};
            vin[p][3] = {2'b11, 4'(p), 4'h2};
            for (int k = 0; k < 4; k++)
                vexp[1][3 + 4 * p + k] = vin[p][k];
        end
        run("t4_contend", 21);

        // round robin: o0 from ptr 0, then o1 pointer moved to 3 by i2
        do_reset();
        vin[0][0] = 10'h200; vin[0][1] = 10'h300;
        vin[1][0] = 10'h210; vin[1][1] = 10'h310;
        vin[2][0] = 10'h220; vin[2][1] = 10'h320;
        vin[3][0] = 10'h230; vin[3][1] = 10'h330;
        vexp[0][3] = 10'h200; vexp[0][4]  = 10'h300;
        vexp[0][5] = 10'h210; vexp[0][6]  = 10'h310;
        vexp[0][7] = 10'h220; vexp[0][8]  = 10'h320;
        vexp[0][9] = 10'h230; vexp[0][10] = 10'h330;
        vin[2][12] = 10'h221; vin[2][13] = 10'h321;
        vexp[1][15] = 10'h221; vexp[1][16] = 10'h321;
        vin[0][20] = 10'h205; vin[0][21] = 10'h305;
        vin[1][20] = 10'h215; vin[1][21] = 10'h315;
        vin[2][20] = 10'h225; vin[2][21] = 10'h325;
        vin[3][20] = 10'h235; vin[3][21] = 10'h335;
        vexp[1][23] = 10'h235; vexp[1][24] = 10'h335;
        vexp[1][25] = 10'h205; vexp[1][26] = 10'h305;
        vexp[1][27] = 10'h215; vexp[1][28] = 10'h315;
        vexp[1][29] = 10'h225; vexp[1][30] = 10'h325;
        run("t5_rr", 32);

        // 13-flit packet i0 -> o1
        vin[0][0] = 10'h201;
        for (int k = 1; k <= 11; k++)
            vin[0][k] = 10'h100 + 10'(k);
        vin[0][12] = 10'h300;
        for (int k = 0; k <= 12; k++)
            vexp[1][k + 3] = vin[0][k];
        run("t6_long", 17);

        // reset mid-packet: outputs clear at once, buffered flits vanish,
        // stray body/tail after reset dropped, new packet on o2 is clean
        vin[0][0] = 10'h201;
        vin[0][1] = 10'h101; vin[0][2] = 10'h102;
        vin[0][3] = 10'h103; vin[0][4] = 10'h104;
        vin[0][5] = 10'h105; vin[0][6] = 10'h106;
        vrst[6] = 1'b1; vrst[7] = 1'b1;
        vin[0][8] = 10'h107; vin[0][9] = 10'h302;
        vin[0][10] = 10'h2A2; vin[0][11] = 10'h3A2;
        vexp[1][3] = 10'h201; vexp[1][4] = 10'h101;
        vexp[1][5] = 10'h102; vexp[1][6] = 10'h103;
        vexp[2][13] = 10'h2A2; vexp[2][14] = 10'h3A2;
        run("t7_midrst", 16);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
